bit_stream_serializer: RTL and testbench

//   Parallel-in/serial-out word serializer that generates the serial bit stream consumed by
//   the sequence-detector FSM (drives its 'in'). Accepts WIDTH-bit words over a valid/ready

---
 rtl/bit_stream_serializer_pkg.sv | 14 +
 rtl/bit_stream_serializer_tick_divider.sv | 33 +++
 rtl/bit_stream_serializer.sv | 104 ++++++++++
 tb/tb_bit_stream_serializer.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/bit_stream_serializer_pkg.sv
// Shared types and helpers for the bit stream serializer.
package bit_stream_serializer_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // Counter width for a modulus of n, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bit_stream_serializer_tick_divider.sv
// Bit-period divider: counts 0..DIV-1 while enabled, flags period start and wrap.
module tick_divider
  import bit_stream_serializer_pkg::*;
#(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic i_en,
  input  logic i_restart,
  output logic o_tick,
  output logic o_start
);

  localparam int DW = cnt_w(DIV);
  localparam logic [DW-1:0] LAST = DW'(DIV - 1);

  logic [DW-1:0] r_divcnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_divcnt <= '0;
    end else if (i_restart || !i_en || o_tick) begin
      r_divcnt <= '0;
    end else begin
      r_divcnt <= r_divcnt + DW'(1);
    end
  end

  assign o_tick  = (r_divcnt == LAST);
  assign o_start = (r_divcnt == '0);

endmodule

// File: rtl/bit_stream_serializer.sv
// Parallel-in/serial-out serializer with a one-word holding buffer for gap-free streaming.
module bit_stream_serializer
  import bit_stream_serializer_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DIV       = 1,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  output logic             bit_out,
  output logic             bit_valid,
  output logic             busy,
  output logic             word_done
);

  localparam int BW = cnt_w(WIDTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_buf;
  logic [WIDTH-1:0] r_shift;
  logic             r_buf_full;
  logic [BW-1:0]    r_bitcnt;
  logic             w_accept;
  logic             w_load;
  logic             w_shift;
  logic             w_tick;
  logic             w_start;

  assign w_accept = load_valid && !r_buf_full;

  tick_divider #(.DIV(DIV)) u_tick (
    .clk       (clk),
    .reset     (reset),
    .i_en      (r_state == ST_SHIFT),
    .i_restart (w_load),
    .o_tick    (w_tick),
    .o_start   (w_start)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_shift     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_buf_full) begin
          w_load      = 1'b1;
          w_state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (w_tick) begin
          if (r_bitcnt != LAST_BIT) w_shift = 1'b1;
          else if (r_buf_full)      w_load  = 1'b1;
          else                      w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Accept takes priority so a write landing on a drain edge keeps the buffer full.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_buf      <= '0;
      r_buf_full <= 1'b0;
      r_shift    <= '0;
      r_bitcnt   <= '0;
    end else begin
      if (w_accept) begin
        r_buf      <= load_data;
        r_buf_full <= 1'b1;
      end else if (w_load) begin
        r_buf_full <= 1'b0;
      end
      if (w_load) begin
        r_shift  <= r_buf;
        r_bitcnt <= '0;
      end else if (w_shift) begin
        if (MSB_FIRST != 0) r_shift <= {r_shift[WIDTH-2:0], 1'b0};
        else                r_shift <= {1'b0, r_shift[WIDTH-1:1]};
        r_bitcnt <= r_bitcnt + BW'(1);
      end
    end
  end

  assign load_ready = !r_buf_full;
  assign bit_out    = (MSB_FIRST != 0) ? r_shift[WIDTH-1] : r_shift[0];
  assign busy       = (r_state == ST_SHIFT);
  assign bit_valid  = busy && w_start;
  assign word_done  = bit_valid && (r_bitcnt == LAST_BIT);

endmodule

// File: tb/tb_bit_stream_serializer.sv
// Scoreboard bench: three serializer configurations (DIV=1 MSB, DIV=3 MSB, DIV=1 LSB).
module tb_bit_stream_serializer;

  localparam int W = 8;

  typedef struct {
    logic b;
    logic wd;
    int   cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] lv = '0;
  logic [7:0] ld [3];
  logic [2:0] rdy, bo, bv, bsy, wd;
  logic [2:0] last_b = '0;
  int         cyc = 0;
  int         checks = 0;
  int         failures = 0;
  int         nf [3];
  int         last_start [3];
  exp_t       q0[$];
  exp_t       q1[$];
  exp_t       q2[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bit_stream_serializer #(.WIDTH(W), .DIV(1), .MSB_FIRST(1)) u_d0 (
    .clk(clk), .reset(rst), .load_valid(lv[0]), .load_data(ld[0]), .load_ready(rdy[0]),
    .bit_out(bo[0]), .bit_valid(bv[0]), .busy(bsy[0]), .word_done(wd[0]));

  bit_stream_serializer #(.WIDTH(W), .DIV(3), .MSB_FIRST(1)) u_d1 (
    .clk(clk), .reset(rst), .load_valid(lv[1]), .load_data(ld[1]), .load_ready(rdy[1]),
    .bit_out(bo[1]), .bit_valid(bv[1]), .busy(bsy[1]), .word_done(wd[1]));

  bit_stream_serializer #(.WIDTH(W), .DIV(1), .MSB_FIRST(0)) u_d2 (
    .clk(clk), .reset(rst), .load_valid(lv[2]), .load_data(ld[2]), .load_ready(rdy[2]),
    .bit_out(bo[2]), .bit_valid(bv[2]), .busy(bsy[2]), .word_done(wd[2]));

  function automatic int div_of(input int d);
    return (d == 1) ? 3 : 1;
  endfunction

  function automatic int qsize(input int d);
    case (d)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  task automatic push(input int d, input exp_t e);
    case (d)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] expv);
    checks++;
    if (got !== expv) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", nm, got, expv, cyc);
    end
  endtask

  task automatic mon(input int d);
    exp_t e;
    if (bv[d]) begin
      checks++;
      if (qsize(d) == 0) begin
        failures++;
        $display("FAIL spurious_bit dut%0d: bit_valid=1 expected 0 (cyc %0d)", d, cyc);
      end else begin
        case (d)
          0:       e = q0.pop_front();
          1:       e = q1.pop_front();
          default: e = q2.pop_front();
        endcase
        if (bo[d] !== e.b || wd[d] !== e.wd || cyc != e.cyc) begin
          failures++;
          $display("FAIL bit dut%0d: got bit=%0b word_done=%0b cyc=%0d expected bit=%0b word_done=%0b cyc=%0d",
                   d, bo[d], wd[d], cyc, e.b, e.wd, e.cyc);
        end
      end
      last_b[d] = bo[d];
    end else if (bsy[d]) begin
      checks++;
      if (bo[d] !== last_b[d] || wd[d] !== 1'b0) begin
        failures++;
        $display("FAIL hold dut%0d: got bit=%0b word_done=%0b expected bit=%0b word_done=0 (cyc %0d)",
                 d, bo[d], wd[d], last_b[d], cyc);
      end
    end else begin
      checks++;
      if (wd[d] !== 1'b0) begin
        failures++;
        $display("FAIL idle_word_done dut%0d: got 1 expected 0 (cyc %0d)", d, cyc);
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst) for (int d = 0; d < 3; d++) mon(d);
  end

  // Offer one word; expected bit times follow from accept edge and the previous word's end.
  task automatic send(input int d, input logic [7:0] w, input bit hold);
    exp_t e;
    int   t0;
    int   k;
    k = 0;
    @(negedge clk);
    while (!rdy[d]) begin
      k++;
      if (k > 200) begin
        checks++;
        failures++;
        $display("FAIL ready_timeout dut%0d: load_ready stuck 0 expected 1", d);
        lv[d] = 1'b0;
        return;
      end
      @(negedge clk);
    end
    ld[d] = w;
    lv[d] = 1'b1;
    t0 = (cyc + 2 > nf[d]) ? cyc + 2 : nf[d];
    nf[d] = t0 + W * div_of(d);
    last_start[d] = t0;
    for (int i = 0; i < W; i++) begin
      e.b   = (d == 2) ? w[i] : w[W-1-i];
      e.wd  = (i == W - 1);
      e.cyc = t0 + i * div_of(d);
      push(d, e);
    end
    @(posedge clk);
    @(negedge clk);
    if (!hold) lv[d] = 1'b0;
  endtask

  task automatic wait_drain(input int d);
    int k;
    k = 0;
    while (qsize(d) != 0 && k < 400) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (qsize(d) != 0) begin
      failures++;
      $display("FAIL drain_timeout dut%0d: %0d bits outstanding expected 0", d, qsize(d));
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int s;
    for (int d = 0; d < 3; d++) begin
      ld[d] = 8'h00;
      nf[d] = 0;
      last_start[d] = 0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++)
      chk($sformatf("reset_state_dut%0d", d), {3'b0, rdy[d], bsy[d], bv[d], bo[d], wd[d]}, 8'h10);
    rst = 1'b0;

    // Single word, immediate serialization
    send(0, 8'hF0, 1'b0);
    wait_drain(0);
    chk("t1_idle_outputs", {5'b0, bsy[0], bo[0], rdy[0]}, 8'h01);

    // Held valid, back-to-back words with no bubble
    send(0, 8'hFF, 1'b1);
    send(0, 8'h00, 1'b0);
    chk("t2_ready_while_buffered", {7'b0, rdy[0]}, 8'h00);
    while (cyc < last_start[0]) @(negedge clk);
    chk("t2_ready_after_drain", {7'b0, rdy[0]}, 8'h01);
    wait_drain(0);
    chk("t2_idle_outputs", {5'b0, bsy[0], bo[0], rdy[0]}, 8'h01);

    // DIV=3 single word, then back-to-back
    send(1, 8'hA5, 1'b0);
    wait_drain(1);
    chk("t3_idle_hold_last_bit", {5'b0, bsy[1], bo[1], rdy[1]}, 8'h03);
    send(1, 8'h3C, 1'b1);
    send(1, 8'h81, 1'b0);
    wait_drain(1);

    // LSB-first
    send(2, 8'h01, 1'b0);
    wait_drain(2);
    chk("t5_idle_outputs", {5'b0, bsy[2], bo[2], rdy[2]}, 8'h01);

    // Asynchronous reset mid-word with a word buffered
    send(0, 8'hC3, 1'b1);
    s = last_start[0];
    send(0, 8'h3C, 1'b0);
    while (cyc < s + 1) @(negedge clk);
    chk("t4_pre_reset_busy", {6'b0, bsy[0], bo[0]}, 8'h03);
    #2 rst = 1'b1;
    q0.delete();
    q1.delete();
    q2.delete();
    for (int d = 0; d < 3; d++) nf[d] = 0;
    last_b = '0;
    #1;
    chk("t4_async_reset_outputs", {3'b0, rdy[0], bsy[0], bv[0], bo[0], wd[0]}, 8'h10);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("t4_after_release", {6'b0, rdy[0], bsy[0]}, 8'h02);
    repeat (30) @(negedge clk);
    chk("t4_quiet_after_reset", {5'b0, rdy[0], bsy[0], bo[0]}, 8'h04);

    for (int d = 0; d < 3; d++)
      chk($sformatf("final_queue_empty_dut%0d", d), 8'(qsize(d)), 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
